// File: rtl/regs.sv
// 31-entry integer register file with same-cycle write bypass, committed-write
// counter and a four-phase debug port that defers debug writes behind core writes.
module regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  reg1_raddr_i,
  input  logic [4:0]  reg2_raddr_i,
  output logic [31:0] reg1_rdata_o,
  output logic [31:0] reg2_rdata_o,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        reg_wen_i,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [4:0]  dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_ack_o,
  output logic [31:0] wb_cnt_o
);
  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;

  typedef enum logic [1:0] {IDLE, PEND, ACK} dbg_state_t;

  typedef struct packed {
    logic            we;
    logic [4:0]      addr;
    logic [XLEN-1:0] wdata;
  } dbg_req_t;

  logic [XLEN-1:0] rf [1:NUM_REGS-1];
  dbg_state_t      state_q, state_d;
  dbg_req_t        dbg_q;
  logic            core_wr, dbg_wr, dbg_rd;

  // x0 is hardwired; a same-cycle core write to the read address wins over storage.
  function automatic logic [XLEN-1:0] read_rf(input logic [4:0] a);
    if (a == 5'd0)                          return '0;
    else if (reg_wen_i && reg_waddr_i == a) return reg_wdata_i;
    else                                    return rf[a];
  endfunction

  always_comb begin
    reg1_rdata_o = read_rf(reg1_raddr_i);
    reg2_rdata_o = read_rf(reg2_raddr_i);
  end

  assign core_wr = reg_wen_i && (reg_waddr_i != 5'd0);
  // Debug writes only commit on a cycle the core leaves the write port idle.
  assign dbg_wr  = (state_q == PEND) && dbg_q.we && !reg_wen_i && (dbg_q.addr != 5'd0);
  assign dbg_rd  = (state_q == PEND) && !dbg_q.we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (core_wr && reg_waddr_i == 5'(i))     rf[i] <= reg_wdata_i;
        else if (dbg_wr && dbg_q.addr == 5'(i))  rf[i] <= dbg_q.wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          wb_cnt_o <= '0;
    else if (core_wr) wb_cnt_o <= wb_cnt_o + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dbg_q       <= '0;
      dbg_rdata_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && dbg_req_i)
        dbg_q <= '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i};
      if (dbg_rd)
        dbg_rdata_o <= read_rf(dbg_q.addr);
    end
  end

  always_comb begin
    state_d   = state_q;
    dbg_ack_o = 1'b0;
    case (state_q)
      IDLE: if (dbg_req_i) state_d = PEND;
      PEND: if (!dbg_q.we || !reg_wen_i) state_d = ACK;
      ACK: begin
        dbg_ack_o = 1'b1;
        if (!dbg_req_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
